bitrev_reorder_buf: RTL and testbench
=====================================

// Module: bitrev_reorder_buf
// PURPOSE
//  Streaming reorder buffer for R2SDF FFT output: takes 2^N samples per frame in bit-reversed order and emits them in natural order.
//  Ping-pong (two-bank) memory gives sustained 1 sample/clk throughput. Valid/ready handshake on both sides.
//  Sits between the last SDF butterfly stage and downstream consumers. Replaces the static init-time shuffle index table.
// PARAMETERS
//  N        3   log2 frame length; frame = 2^N samples; N >= 1
//  DATA_W   16  sample width in bits (complex packed, opaque to this block)
//  REORDER  1   1 = bit-reverse reorder; 0 = identity (natural pass-through through the same banks, same latency)
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  flush      in   1       synchronous frame abort; discards all buffered/partial frames
//  in_valid   in   1       input sample valid
//  in_ready   out  1       block can accept input
//  in_data    in   DATA_W  input sample
//  out_valid  out  1       output sample valid
//  out_ready  in   1       downstream accepts output
//  out_data   out  DATA_W  output sample (registered)
//  out_last   out  1       last sample of frame (only with SHUFFLE_LAST_EN)
// BEHAVIOUR
//  - Storage: mem[2][2^N] x DATA_W; per-bank full flag bank_full[1:0]; wr_bank, rd_bank 1-bit; wcnt, rcnt N-bit.
//  - Reset (rst_n=0, async): bank_full=0, wr_bank=rd_bank=0, wcnt=rcnt=0, out_valid=0, out_data=0, out_last=0; memory not cleared.
//  - in_ready = !bank_full[wr_bank] && !flush (combinational).
//  - Write on in_valid&&in_ready: mem[wr_bank][addr] <= in_data, addr = REORDER ? bitrev_N(wcnt) : wcnt; wcnt++.
//    When wcnt == 2^N-1: wcnt wraps to 0, bank_full[wr_bank] <= 1, wr_bank toggles.
//  - Read load condition: bank_full[rd_bank] && (!out_valid || out_ready) && !flush.
//    On load: out_data <= mem[rd_bank][rcnt], out_valid <= 1, rcnt++.
//    When rcnt == 2^N-1: rcnt wraps to 0, bank_full[rd_bank] <= 0, rd_bank toggles.
//  - No load && out_ready: out_valid <= 0. No load && !out_ready: out_valid/out_data hold (stable while stalled).
//  - Latency: first out_valid is high in the 2nd cycle after the edge that accepts the frame's final input.
//  - Throughput: with out_ready=1 continuously, in_ready never deasserts; no bubbles between frames on either side.
//  - Simultaneous set/clear of bank_full on the same edge always targets different banks; both take effect.
//  - Both banks full: in_ready=0 until the read side frees a bank; in_ready rises the cycle after the final read load.
//  - Back-pressure mid-frame (out_ready=0): rcnt frozen, sample held, no loss or duplication.
//  - flush=1 (sync, priority over all handshakes): bank_full=0, wr_bank=rd_bank=0, wcnt=rcnt=0, out_valid=0, out_last=0 next edge.
//    No handshake completes on either side during the flush cycle.
//  - bitrev_N(k): output bit i = k bit N-1-i, i = 0..N-1.
// CONFIGURATION
//  SHUFFLE_LAST_EN defined:
//    out_last port exists; loaded with out_data, =1 when the loaded rcnt == 2^N-1, else 0; holds under stall.
//  SHUFFLE_LAST_EN undefined:
//    out_last port and its register absent; all other behaviour identical.
// TESTING (N=3, DATA_W=16, REORDER=1 unless noted)
//  1 Reset: assert rst_n=0 mid-frame -> out_valid=0, in_ready=1 immediately;
//    after release, frame 0..7 -> out 0,4,2,6,1,5,3,7.
//  2 Streaming: 4 back-to-back frames (data = frame*8+k), out_ready=1 -> in_ready stays 1;
//    each frame emitted in bit-reversed permutation, no gaps after first output.
//  3 Back-pressure: 3 frames sent, out_ready=0 -> in_ready=0 after 16 accepted samples;
//    random out_ready afterwards -> 24 outputs in correct order, none lost or duplicated.
//  4 Flush: 5 samples of frame into empty buffer, flush=1 one cycle, then frame 0..7 -> out exactly 0,4,2,6,1,5,3,7;
//    no stale data emitted.
//  5 REORDER=0: frame 10..17 -> out 10..17 in order; latency identical to REORDER=1.
//  6 SHUFFLE_LAST_EN: out_last=1 only with out_data=7 (REORDER=1); holds across a 3-cycle out_ready=0 stall.

Source files
------------

// File: rtl/bitrev_reorder_buf.sv
// bitrev_reorder_buf: ping-pong reorder buffer turning bit-reversed FFT frames into natural order
// Frames of 2^N samples are written into one bank while the other bank is read out,
// giving 1 sample/clk sustained throughput.
// Ports: clk, rst_n (async active-low), flush (sync abort),
//        in_valid/in_ready/in_data (write side), out_valid/out_ready/out_data (registered read side),
//        out_last (end-of-frame marker, present only when SHUFFLE_LAST_EN is defined).
// Optional feature macro: SHUFFLE_LAST_EN
module bitrev_reorder_buf #(
    parameter int N       = 3,
    parameter int DATA_W  = 16,
    parameter int REORDER = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef SHUFFLE_LAST_EN
    ,
    output logic              out_last
`endif
);
    logic [DATA_W-1:0] mem [2][2**N];
    logic [1:0]        bank_full;
    logic              wr_bank, rd_bank;
    logic [N-1:0]      wcnt, rcnt, wrev, waddr;
    logic              wr_en, ld;
    always_comb begin
        wrev = '0;
        for (int i = 0; i < N; i++) wrev[i] = wcnt[N-1-i];
    end
    // Scattering writes to bit-reversed addresses lets the read side walk linearly.
    assign waddr    = (REORDER != 0) ? wrev : wcnt;
    assign in_ready = !bank_full[wr_bank] && !flush;
    assign wr_en    = in_valid && in_ready;
    assign ld       = bank_full[rd_bank] && (!out_valid || out_ready) && !flush;
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_bank][waddr] <= in_data;
    end
    // A write only ever fills the bank not being drained, so a set and a clear
    // of bank_full on the same edge always touch different bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_full <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wcnt      <= '0;
            rcnt      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
`ifdef SHUFFLE_LAST_EN
            out_last  <= 1'b0;
`endif
        end else if (flush) begin
            bank_full <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wcnt      <= '0;
            rcnt      <= '0;
            out_valid <= 1'b0;
`ifdef SHUFFLE_LAST_EN
            out_last  <= 1'b0;
`endif
        end else begin
            if (wr_en) begin
                wcnt <= wcnt + 1'b1;
                if (&wcnt) begin
                    bank_full[wr_bank] <= 1'b1;
                    wr_bank            <= ~wr_bank;
                end
            end
            if (ld) begin
                out_data  <= mem[rd_bank][rcnt];
                out_valid <= 1'b1;
                rcnt      <= rcnt + 1'b1;
`ifdef SHUFFLE_LAST_EN
                out_last  <= &rcnt;
`endif
                if (&rcnt) begin
                    bank_full[rd_bank] <= 1'b0;
                    rd_bank            <= ~rd_bank;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bitrev_reorder_buf.sv
// tb_bitrev_reorder_buf: scoreboard bench for the bit-reversal reorder buffer (REORDER=1 and REORDER=0 side by side)
module tb_bitrev_reorder_buf;
    localparam int N = 3;
    localparam int W = 16;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [W-1:0] out_data_a, out_data_b;
`ifdef SHUFFLE_LAST_EN
    logic         out_last_a, out_last_b;
`endif
    logic [W:0]   qa[$], qb[$];
    logic [W:0]   ea, eb;
    int compared = 0, mismatched = 0;
    int cyc = 0, acc = 0, stalls = 0, gaps = 0, nx = 0, last_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    bitrev_reorder_buf #(.N(N), .DATA_W(W), .REORDER(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a)
`ifdef SHUFFLE_LAST_EN
        , .out_last(out_last_a)
`endif
    );

    bitrev_reorder_buf #(.N(N), .DATA_W(W), .REORDER(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b)
`ifdef SHUFFLE_LAST_EN
        , .out_last(out_last_b)
`endif
    );

    function automatic int rev(input int k);
        int r = 0;
        for (int i = 0; i < N; i++) if (k[i]) r |= 1 << (N-1-i);
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n && !flush && out_valid_a && out_ready) begin
            if (nx > 0 && cyc != last_cyc + 1) gaps++;
            last_cyc = cyc;
            nx++;
            compared++;
            if (qa.size() == 0) begin
                mismatched++;
                $display("FAIL out_a_unexpected got %0d expected nothing", out_data_a);
            end else begin
                ea = qa.pop_front();
                if (out_data_a !== ea[W-1:0]) begin
                    mismatched++;
                    $display("FAIL out_a_data got %0d expected %0d", out_data_a, ea[W-1:0]);
                end
`ifdef SHUFFLE_LAST_EN
                if (out_last_a !== ea[W]) begin
                    mismatched++;
                    $display("FAIL out_a_last got %0b expected %0b", out_last_a, ea[W]);
                end
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && !flush && out_valid_b && out_ready) begin
            compared++;
            if (qb.size() == 0) begin
                mismatched++;
                $display("FAIL out_b_unexpected got %0d expected nothing", out_data_b);
            end else begin
                eb = qb.pop_front();
                if (out_data_b !== eb[W-1:0]) begin
                    mismatched++;
                    $display("FAIL out_b_data got %0d expected %0d", out_data_b, eb[W-1:0]);
                end
            end
        end
    end

    task automatic put(input int d);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = W'(d);
        for (int t = 0; t < 500 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready_a;
            if (!ok) stalls++;
            @(posedge clk);
            #1;
        end
        if (ok) acc++;
        else begin
            compared++;
            mismatched++;
            $display("FAIL put_timeout got in_ready=0 expected 1 within 500 cycles");
        end
    endtask

    task automatic send_frame(input int base);
        for (int j = 0; j < 8; j++) begin
            qa.push_back({j == 7, W'(base + rev(j))});
            qb.push_back({j == 7, W'(base + j)});
        end
        for (int k = 0; k < 8; k++) put(base + k);
    endtask

    task automatic drain();
        for (int t = 0; t < 300 && (qa.size() != 0 || qb.size() != 0); t++) @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        compared++;
        if (qa.size() != 0 || qb.size() != 0) begin
            mismatched++;
            $display("FAIL drain got %0d/%0d pending expected 0/0", qa.size(), qb.size());
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_state got valid=%0b ready=%0b expected 0/1", out_valid_a, in_ready_a);
        end
        rst_n = 1'b1;
        out_ready = 1'b0;
        send_frame(200);
        for (int k = 0; k < 5; k++) put(208 + k);
        in_valid = 1'b0;
        @(negedge clk);
        compared++;
        if (out_valid_a !== 1'b1) begin
            mismatched++;
            $display("FAIL pre_reset_valid got %0b expected 1", out_valid_a);
        end
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0 || in_ready_a !== 1'b1) begin
            mismatched++;
            $display("FAIL async_reset got valid=%0b/%0b ready=%0b expected 0/0/1", out_valid_a, out_valid_b, in_ready_a);
        end
        qa.delete();
        qb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        send_frame(0);
        in_valid = 1'b0;
        drain();
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        stalls = 0;
        gaps = 0;
        nx = 0;
        for (int f = 0; f < 4; f++) send_frame(f * 8);
        in_valid = 1'b0;
        drain();
        compared++;
        if (stalls != 0) begin
            mismatched++;
            $display("FAIL stream_in_ready got %0d stalls expected 0", stalls);
        end
        compared++;
        if (gaps != 0 || nx != 32) begin
            mismatched++;
            $display("FAIL stream_gaps got gaps=%0d outs=%0d expected 0/32", gaps, nx);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        acc = 0;
        fork
            begin
                for (int f = 0; f < 3; f++) send_frame(100 + f * 8);
                in_valid = 1'b0;
            end
            begin
                for (int t = 0; t < 200 && acc < 16; t++) @(posedge clk);
                repeat (4) @(posedge clk);
                @(negedge clk);
                compared++;
                if (acc != 16 || in_ready_a !== 1'b0) begin
                    mismatched++;
                    $display("FAIL bp_full got acc=%0d ready=%0b expected 16/0", acc, in_ready_a);
                end
                compared++;
                if (out_valid_a !== 1'b1 || out_data_a !== W'(100)) begin
                    mismatched++;
                    $display("FAIL bp_hold got valid=%0b data=%0d expected 1/100", out_valid_a, out_data_a);
                end
                for (int t = 0; t < 3000 && (qa.size() != 0 || in_valid); t++) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        drain();
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) put(50 + k);
        flush = 1'b1;
        in_data = W'(99);
        @(negedge clk);
        compared++;
        if (in_ready_a !== 1'b0) begin
            mismatched++;
            $display("FAIL flush_ready got %0b expected 0", in_ready_a);
        end
        @(posedge clk);
        #1 flush = 1'b0;
        in_valid = 1'b0;
        send_frame(0);
        in_valid = 1'b0;
        drain();
    endtask

    task automatic test_reorder0();
        out_ready = 1'b1;
        send_frame(10);
        in_valid = 1'b0;
        @(negedge clk);
        compared++;
        if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0) begin
            mismatched++;
            $display("FAIL latency_early got %0b/%0b expected 0/0", out_valid_a, out_valid_b);
        end
        @(negedge clk);
        compared++;
        if (out_valid_a !== 1'b1 || out_valid_b !== 1'b1) begin
            mismatched++;
            $display("FAIL latency_first got %0b/%0b expected 1/1", out_valid_a, out_valid_b);
        end
        drain();
    endtask

`ifdef SHUFFLE_LAST_EN
    task automatic test_last();
        bit found = 1'b0;
        out_ready = 1'b0;
        send_frame(0);
        in_valid = 1'b0;
        for (int t = 0; t < 100 && !found; t++) begin
            @(negedge clk);
            if (out_valid_a && out_data_a == W'(7)) found = 1'b1;
            else if (out_valid_a) begin
                compared++;
                if (out_last_a !== 1'b0) begin
                    mismatched++;
                    $display("FAIL last_early got %0b expected 0 at data %0d", out_last_a, out_data_a);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
                @(posedge clk);
                #1 out_ready = 1'b0;
            end
        end
        for (int s = 0; s < 3; s++) begin
            compared++;
            if (!found || out_last_a !== 1'b1 || out_data_a !== W'(7)) begin
                mismatched++;
                $display("FAIL last_hold got last=%0b data=%0d expected 1/7", out_last_a, out_data_a);
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();
    endtask
`endif

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_reorder0();
`ifdef SHUFFLE_LAST_EN
        test_last();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
